// File: rtl/branch_pc_redirect.sv
// Fetch PC sequencer with beq prediction and one-slot mispredict redirect.
// Optional fetch/mispredict statistics counters enabled by macro BP_STAT_EN.
module branch_pc_redirect (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        istall,
  input  logic [31:0] iInstruction,
  input  logic [1:0]  ibp_predict,
  output logic [31:0] oPC,
  output logic        oflush,
  output logic [15:0] obr_cnt,
  output logic [15:0] omiss_cnt
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNTW   = 16;
  localparam int unsigned OPW    = 6;
  localparam logic [OPW-1:0] OP_BEQ = OPW'(4);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_alt_d;
  logic [XLEN-1:0] r_alt_e;
  logic            r_vd;
  logic            r_ve;

  logic            w_is_beq;
  logic [XLEN-1:0] w_seq;
  logic [XLEN-1:0] w_off;
  logic [XLEN-1:0] w_target;
  logic            w_redirect;
  logic            w_unused;

  assign w_is_beq   = (iInstruction[31:26] == OP_BEQ);
  assign w_seq      = r_pc + XLEN'(4);
  assign w_off      = {{(XLEN-18){iInstruction[15]}}, iInstruction[15:0], 2'b00};
  assign w_target   = w_seq + w_off;
  assign w_redirect = ibp_predict[1] & r_ve;
  assign w_unused   = ^iInstruction[25:16];

  assign oPC    = r_pc;
  assign oflush = w_redirect;

  // Redirect beats stall; otherwise the alternate path shifts D->E each fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_alt_d <= '0;
      r_alt_e <= '0;
      r_vd    <= 1'b0;
      r_ve    <= 1'b0;
    end else if (w_redirect) begin
      r_pc <= r_alt_e;
      r_vd <= 1'b0;
      r_ve <= 1'b0;
    end else if (!istall) begin
      r_alt_e <= r_alt_d;
      r_ve    <= r_vd;
      if (w_is_beq) begin
        r_vd <= 1'b1;
        if (ibp_predict[0]) begin
          r_pc    <= w_target;
          r_alt_d <= w_seq;
        end else begin
          r_pc    <= w_seq;
          r_alt_d <= w_target;
        end
      end else begin
        r_pc <= w_seq;
        r_vd <= 1'b0;
      end
    end
  end

`ifdef BP_STAT_EN
  logic [CNTW-1:0] r_br_cnt;
  logic [CNTW-1:0] r_miss_cnt;
  logic            w_fetch_beq;

  assign w_fetch_beq = w_is_beq & ~istall & ~w_redirect;

  // Saturating statistics; a squashed or stalled beq is not a fetch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_br_cnt   <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (w_fetch_beq && (r_br_cnt != '1)) r_br_cnt <= r_br_cnt + CNTW'(1);
      if (w_redirect && (r_miss_cnt != '1)) r_miss_cnt <= r_miss_cnt + CNTW'(1);
    end
  end

  assign obr_cnt   = r_br_cnt;
  assign omiss_cnt = r_miss_cnt;
`else
  assign obr_cnt   = CNTW'(0);
  assign omiss_cnt = CNTW'(0);
`endif

endmodule

// File: tb/tb_branch_pc_redirect.sv
// Scoreboard bench for branch_pc_redirect: driver queues expectations, monitor checks.
module tb_branch_pc_redirect;

  logic        clk;
  logic        rst_n;
  logic        istall;
  logic [31:0] iInstruction;
  logic [1:0]  ibp_predict;
  logic [31:0] oPC;
  logic        oflush;
  logic [15:0] obr_cnt;
  logic [15:0] omiss_cnt;

  branch_pc_redirect dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .istall       (istall),
    .iInstruction (iInstruction),
    .ibp_predict  (ibp_predict),
    .oPC          (oPC),
    .oflush       (oflush),
    .obr_cnt      (obr_cnt),
    .omiss_cnt    (omiss_cnt)
  );

  typedef struct {
    bit          is_rst;
    bit          exp_flush;
    logic [31:0] exp_pc;
    logic [15:0] exp_br;
    logic [15:0] exp_miss;
    int          id;
  } item_t;

  item_t       q[$];
  int          total;
  int          bad;
  int          id_ctr;
  logic [15:0] m_br;
  logic [15:0] m_miss;

`ifdef BP_STAT_EN
  localparam int NSAT = 65540;
`else
  localparam int NSAT = 24;
`endif

  localparam logic [31:0] NOP = 32'h0000_0000;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s id=%0d got=%h want=%h", nm, id, act, exp);
    end
  endtask

  task automatic push_item(input bit is_rst, input bit flush, input logic [31:0] pc_next);
    item_t it;
    it.is_rst    = is_rst;
    it.exp_flush = flush;
    it.exp_pc    = pc_next;
`ifdef BP_STAT_EN
    it.exp_br    = m_br;
    it.exp_miss  = m_miss;
`else
    it.exp_br    = 16'h0000;
    it.exp_miss  = 16'h0000;
`endif
    it.id  = id_ctr;
    id_ctr = id_ctr + 1;
    q.push_back(it);
  endtask

  task automatic step(input logic [31:0] instr, input logic [1:0] pred, input logic stall,
                      input bit flush, input logic [31:0] pc_next);
    @(negedge clk);
    rst_n        = 1'b1;
    iInstruction = instr;
    ibp_predict  = pred;
    istall       = stall;
    if (flush) begin
      if (m_miss != 16'hFFFF) m_miss = m_miss + 16'd1;
    end else if (!stall && instr[31:26] == 6'd4) begin
      if (m_br != 16'hFFFF) m_br = m_br + 16'd1;
    end
    push_item(1'b0, flush, pc_next);
  endtask

  // Asynchronous reset mid-cycle; a spurious mispredict is presented to prove oflush stays low.
  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    ibp_predict  = 2'b10;
    istall       = 1'b0;
    iInstruction = NOP;
    m_br         = 16'h0000;
    m_miss       = 16'h0000;
    push_item(1'b1, 1'b0, 32'h0000_0000);
  endtask

  initial begin : monitor
    item_t it;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        it = q.pop_front();
        chk("oflush", it.id, 32'(oflush), 32'(it.exp_flush));
        if (it.is_rst) begin
          chk("rst_pc", it.id, oPC, 32'h0000_0000);
          chk("rst_br", it.id, 32'(obr_cnt), 32'h0);
          chk("rst_miss", it.id, 32'(omiss_cnt), 32'h0);
        end else begin
          @(posedge clk);
          #1;
          chk("pc", it.id, oPC, it.exp_pc);
          chk("br_cnt", it.id, 32'(obr_cnt), 32'(it.exp_br));
          chk("miss_cnt", it.id, 32'(omiss_cnt), 32'(it.exp_miss));
        end
      end
    end
  end

  initial begin : driver
    logic [31:0] pc;
    int          w;
    total        = 0;
    bad          = 0;
    id_ctr       = 0;
    m_br         = 16'h0000;
    m_miss       = 16'h0000;
    rst_n        = 1'b0;
    istall       = 1'b0;
    iInstruction = NOP;
    ibp_predict  = 2'b00;

    do_reset();
    step(NOP, 2'b00, 1'b0, 1'b0, 32'h04);
    step(NOP, 2'b00, 1'b0, 1'b0, 32'h08);
    step(NOP, 2'b00, 1'b0, 1'b0, 32'h0C);
    step(NOP, 2'b00, 1'b0, 1'b0, 32'h10);
    // Predicted-taken beq, then mispredict two fetches later.
    step(32'h1000_0003, 2'b01, 1'b0, 1'b0, 32'h20);
    step(NOP,           2'b00, 1'b0, 1'b0, 32'h24);
    step(NOP,           2'b10, 1'b0, 1'b1, 32'h14);
    step(32'h1000_000A, 2'b01, 1'b0, 1'b0, 32'h40);
    // Predicted not-taken backward beq; mispredict squashes the beq fetched alongside.
    step(32'h1000_FFFE, 2'b00, 1'b0, 1'b0, 32'h44);
    step(NOP,           2'b00, 1'b0, 1'b0, 32'h48);
    step(32'h1000_0003, 2'b11, 1'b0, 1'b1, 32'h3C);
    // Stall holds PC and pipeline; redirect overrides stall.
    step(32'h1000_0001, 2'b01, 1'b0, 1'b0, 32'h44);
    step(NOP,           2'b00, 1'b1, 1'b0, 32'h44);
    step(32'h1000_0001, 2'b01, 1'b1, 1'b0, 32'h44);
    step(NOP,           2'b00, 1'b1, 1'b0, 32'h44);
    step(NOP,           2'b00, 1'b0, 1'b0, 32'h48);
    step(NOP,           2'b10, 1'b1, 1'b1, 32'h40);
    // Spurious mispredicts with no valid alternate, then wrap-around.
    step(NOP,           2'b10, 1'b0, 1'b0, 32'h44);
    step(NOP,           2'b10, 1'b0, 1'b0, 32'h48);
    step(32'h1000_FFEC, 2'b01, 1'b0, 1'b0, 32'hFFFF_FFFC);
    step(NOP,           2'b00, 1'b0, 1'b0, 32'h00);
    step(NOP,           2'b00, 1'b0, 1'b0, 32'h04);
    // Reset while an alternate is valid in E.
    step(32'h1000_0002, 2'b00, 1'b0, 1'b0, 32'h08);
    step(NOP,           2'b00, 1'b0, 1'b0, 32'h0C);
    do_reset();
    step(NOP,           2'b00, 1'b0, 1'b0, 32'h04);
    step(NOP,           2'b00, 1'b0, 1'b0, 32'h08);
    step(NOP,           2'b10, 1'b0, 1'b0, 32'h0C);
    // Branch counter saturation with zero-offset beqs.
    pc = 32'h0C;
    for (int i = 0; i < NSAT; i++) begin
      step(32'h1000_0000, 2'b01, 1'b0, 1'b0, pc + 32'd4);
      pc = pc + 32'd4;
    end

    w = 0;
    while (q.size() > 0 && w < 50) begin
      @(posedge clk);
      w = w + 1;
    end
    repeat (3) @(negedge clk);
    if (q.size() > 0) begin
      total = total + 1;
      bad   = bad + 1;
      $display("FAIL drain pending=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
